// File: rtl/key_switch_conditioner_pkg.sv
// Shared types for the slc3 key/switch front end: debounce state encoding
// and default channel sizing.
package lc3b_types;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } db_state_t;

   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int unsigned DEFAULT_SYNC_STAGES     = 2;
   localparam int unsigned DEFAULT_SW_WIDTH        = 16;

   // "away" means the level differs from the channel's reset (idle) value.
   function automatic db_state_t settled_state(input logic away);
      return away ? PRESSED : RELEASED;
   endfunction

   function automatic db_state_t waiting_state(input logic away);
      return away ? RELEASE_WAIT : PRESS_WAIT;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: multi-flop synchronizer, stability counter, registered
// stable level and a one-cycle strobe on a debounced 1->0 (1-bit channels only).
module debounce_channel
   import lc3b_types::*;
#(
   parameter int unsigned      WIDTH           = 1,
   parameter int unsigned      SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int unsigned      DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] stable,
   output logic             fall
);

   localparam int unsigned      CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam bit               HAS_STROBE = (WIDTH == 1);

   logic [WIDTH-1:0] sync [SYNC_STAGES];
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] s_prev;
   logic [CNT_W-1:0] count;
   db_state_t        state;

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the synchronizer flops are reset as well, so a sample taken
         // before reset can never seed a count once reset is released.
         for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= RESET_VAL;
         s_prev <= RESET_VAL;
         stable <= RESET_VAL;
         count  <= '0;
         fall   <= 1'b0;
         state  <= RELEASED;
      end else begin
         sync[0] <= raw;
         for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
         s_prev <= s;
         fall   <= 1'b0;

         case (state)
            RELEASED, PRESSED: begin
               // Settled: s_prev always equals stable here, so a new level
               // starts its count from zero.
               count <= '0;
               if (s != stable) state <= waiting_state(state == PRESSED);
            end
            PRESS_WAIT, RELEASE_WAIT: begin
               if (s == stable) begin
                  count <= '0;
                  state <= settled_state(state == RELEASE_WAIT);
               end else if (s != s_prev) begin
                  count <= '0;
               end else if (count == CNT_LAST) begin
                  stable <= s;
                  count  <= '0;
                  state  <= settled_state(s != RESET_VAL);
                  fall   <= HAS_STROBE && stable[0] && !s[0];
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: begin
               count <= '0;
               state <= RELEASED;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_switch_conditioner.sv
// slc3 input front end: debounces the active-low Run/Continue keys and the
// slide-switch vector, and emits one-cycle press strobes for the keys.
module key_switch_conditioner
   import lc3b_types::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int unsigned SW_WIDTH        = DEFAULT_SW_WIDTH
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                Run_raw,
   input  logic                Continue_raw,
   input  logic [SW_WIDTH-1:0] Switches_raw,
   output logic                Run,
   output logic                Continue,
   output logic                Run_press,
   output logic                Continue_press,
   output logic [SW_WIDTH-1:0] Switches
);

   logic switches_fall_unused;

   debounce_channel #(
      .WIDTH           (1),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b1)
   ) u_run (
      .clk    (Clk),
      .reset  (Reset),
      .raw    (Run_raw),
      .stable (Run),
      .fall   (Run_press)
   );

   debounce_channel #(
      .WIDTH           (1),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b1)
   ) u_continue (
      .clk    (Clk),
      .reset  (Reset),
      .raw    (Continue_raw),
      .stable (Continue),
      .fall   (Continue_press)
   );

   // The whole vector is one channel so only a fully settled pattern is ever
   // presented to slc3.
   debounce_channel #(
      .WIDTH           (SW_WIDTH),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       ({SW_WIDTH{1'b0}})
   ) u_switches (
      .clk    (Clk),
      .reset  (Reset),
      .raw    (Switches_raw),
      .stable (Switches),
      .fall   (switches_fall_unused)
   );

endmodule

// File: tb/tb_key_switch_conditioner.sv
// Directed bench for key_switch_conditioner with a per-cycle behavioural model
// (a value must hold DEBOUNCE_CYCLES+1 synchronized samples to be accepted).
module tb_key_switch_conditioner;

   localparam int D    = 4;
   localparam int SYNC = 2;
   localparam int SW   = 16;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Run_raw;
   logic          Continue_raw;
   logic [SW-1:0] Switches_raw;
   logic          Run;
   logic          Continue;
   logic          Run_press;
   logic          Continue_press;
   logic [SW-1:0] Switches;

   key_switch_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .SYNC_STAGES     (SYNC),
      .SW_WIDTH        (SW)
   ) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .Run_raw        (Run_raw),
      .Continue_raw   (Continue_raw),
      .Switches_raw   (Switches_raw),
      .Run            (Run),
      .Continue       (Continue),
      .Run_press      (Run_press),
      .Continue_press (Continue_press),
      .Switches       (Switches)
   );

   always #5 Clk = ~Clk;

   int n_vec    = 0;
   int n_miss   = 0;
   int edge_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_cnt, act, exp);
      end
   endtask

   // Model: channel 0 = Run, 1 = Continue, 2 = Switches.
   logic [15:0] pipe     [3][SYNC];
   logic [15:0] prev_s   [3];
   logic [15:0] m_stable [3];
   logic        m_press  [3];
   int          run_len  [3];
   logic [15:0] m_raw    [3];
   logic [15:0] m_s;

   function automatic logic [15:0] idle_val(input int ch);
      return (ch < 2) ? 16'h0001 : 16'h0000;
   endfunction

   always @(posedge Clk) begin
      edge_cnt++;
      m_raw[0] = {15'b0, Run_raw};
      m_raw[1] = {15'b0, Continue_raw};
      m_raw[2] = Switches_raw;
      for (int ch = 0; ch < 3; ch++) begin
         if (Reset) begin
            for (int k = 0; k < SYNC; k++) pipe[ch][k] = idle_val(ch);
            prev_s[ch]   = idle_val(ch);
            m_stable[ch] = idle_val(ch);
            m_press[ch]  = 1'b0;
            run_len[ch]  = 1;
         end else begin
            m_s = pipe[ch][SYNC-1];
            for (int k = SYNC - 1; k > 0; k--) pipe[ch][k] = pipe[ch][k-1];
            pipe[ch][0] = m_raw[ch];
            run_len[ch] = (m_s == prev_s[ch]) ? run_len[ch] + 1 : 1;
            prev_s[ch]  = m_s;
            m_press[ch] = 1'b0;
            if (m_s != m_stable[ch] && run_len[ch] >= D + 1) begin
               m_press[ch]  = (ch < 2) && m_stable[ch][0] && !m_s[0];
               m_stable[ch] = m_s;
            end
         end
      end
   end

   // Strobe counts and the forbidden intermediate switch pattern.
   int   run_press_cnt  = 0;
   int   cont_press_cnt = 0;
   logic seen_2a        = 1'b0;

   always @(posedge Clk) begin
      if (Run_press === 1'b1) run_press_cnt++;
      if (Continue_press === 1'b1) cont_press_cnt++;
      if (Switches === 16'h002a) seen_2a = 1'b1;
   end

   always @(negedge Clk) begin
      if (edge_cnt > 0) begin
         check("model_run", Run, m_stable[0][0]);
         check("model_continue", Continue, m_stable[1][0]);
         check("model_switches", Switches, m_stable[2]);
         check("model_run_press", Run_press, m_press[0]);
         check("model_continue_press", Continue_press, m_press[1]);
      end
   end

   task automatic wait_edge(input int n);
      while (edge_cnt < n) @(negedge Clk);
   endtask

   int t;
   int snap_r;
   int snap_c;

   initial begin
      Reset        = 1'b1;
      Run_raw      = 1'b0;
      Continue_raw = 1'b0;
      Switches_raw = 16'h002a;

      // Reset held three cycles with keys pressed and switches set.
      repeat (3) begin
         @(negedge Clk);
         check("rst_run", Run, 1'b1);
         check("rst_continue", Continue, 1'b1);
         check("rst_switches", Switches, 16'h0000);
         check("rst_run_press", Run_press, 1'b0);
         check("rst_continue_press", Continue_press, 1'b0);
      end
      Reset        = 1'b0;
      Run_raw      = 1'b1;
      Continue_raw = 1'b1;
      Switches_raw = 16'h0000;
      wait_edge(edge_cnt + 10);

      // Clean Run press, then release.
      snap_r  = run_press_cnt;
      t       = edge_cnt + 1;
      Run_raw = 1'b0;
      wait_edge(t + 5);
      check("run_before_latency", Run, 1'b1);
      check("run_press_early", Run_press, 1'b0);
      wait_edge(t + 6);
      check("run_fall", Run, 1'b0);
      check("run_press_strobe", Run_press, 1'b1);
      wait_edge(t + 7);
      check("run_press_one_cycle", Run_press, 1'b0);
      wait_edge(t + 19);
      Run_raw = 1'b1;
      wait_edge(t + 25);
      check("run_still_low", Run, 1'b0);
      wait_edge(t + 26);
      check("run_release", Run, 1'b1);
      check("run_release_no_strobe", Run_press, 1'b0);
      wait_edge(t + 32);
      check("run_press_count", run_press_cnt - snap_r, 1);

      // Bouncing Continue: only the final settled low is accepted.
      snap_c       = cont_press_cnt;
      t            = edge_cnt + 1;
      Continue_raw = 1'b0;
      wait_edge(t + 1);
      Continue_raw = 1'b1;
      wait_edge(t + 3);
      Continue_raw = 1'b0;
      wait_edge(t + 9);
      check("cont_before_settle", Continue, 1'b1);
      wait_edge(t + 10);
      check("cont_fall", Continue, 1'b0);
      check("cont_press_strobe", Continue_press, 1'b1);
      wait_edge(t + 11);
      check("cont_press_one_cycle", Continue_press, 1'b0);
      wait_edge(t + 20);
      check("cont_press_count", cont_press_cnt - snap_c, 1);

      // Switch vector changes mid-count; the intermediate vector is dropped.
      t            = edge_cnt + 1;
      Switches_raw = 16'h002a;
      wait_edge(t + 2);
      Switches_raw = 16'h002b;
      wait_edge(t + 8);
      check("sw_before_settle", Switches, 16'h0000);
      wait_edge(t + 9);
      check("sw_settled", Switches, 16'h002b);
      wait_edge(t + 15);

      // Reset mid-count on Run discards progress.
      snap_r  = run_press_cnt;
      t       = edge_cnt + 1;
      Run_raw = 1'b0;
      wait_edge(t + 4);
      Reset = 1'b1;
      wait_edge(t + 5);
      Reset = 1'b0;
      check("rst_mid_run", Run, 1'b1);
      check("rst_mid_continue", Continue, 1'b1);
      check("rst_mid_switches", Switches, 16'h0000);
      wait_edge(t + 6);
      check("rst_mid_run_no_commit", Run, 1'b1);
      wait_edge(t + 11);
      check("rst_mid_run_waiting", Run, 1'b1);
      wait_edge(t + 12);
      check("rst_mid_run_fall", Run, 1'b0);
      check("rst_mid_run_press", Run_press, 1'b1);
      wait_edge(t + 20);
      check("rst_mid_press_count", run_press_cnt - snap_r, 1);

      // Simultaneous presses on both keys.
      Run_raw      = 1'b1;
      Continue_raw = 1'b1;
      wait_edge(edge_cnt + 12);
      t            = edge_cnt + 1;
      Run_raw      = 1'b0;
      Continue_raw = 1'b0;
      wait_edge(t + 5);
      check("both_run_press_early", Run_press, 1'b0);
      check("both_cont_press_early", Continue_press, 1'b0);
      wait_edge(t + 6);
      check("both_run_press", Run_press, 1'b1);
      check("both_cont_press", Continue_press, 1'b1);
      wait_edge(t + 7);
      check("both_run_press_end", Run_press, 1'b0);
      check("both_cont_press_end", Continue_press, 1'b0);
      wait_edge(t + 12);

      check("sw_intermediate_never_seen", seen_2a, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
